// File: rtl/mips_cpu_muldiv_ctrl.sv
// rtl/mips_cpu_muldiv_ctrl.sv - iterative MIPS HI/LO multiply/divide unit with fixed 33-cycle latency
module mips_cpu_muldiv_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        rd_req,
   output logic        busy,
   output logic        done,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   state_t      state, state_nxt;
   logic [4:0]  count;
   logic [63:0] acc;
   logic [31:0] opnd_b;
   logic [31:0] rs_save;
   logic        is_div;
   logic        neg_res;
   logic        neg_rem;
   logic        div_zero;

   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   logic [32:0] div_diff;
   logic [63:0] div_next;
   logic [63:0] prod_neg;
   logic [31:0] fix_hi, fix_lo;

   // Signed ops iterate on magnitudes; signs are restored in FIX.
   always_comb begin
      a_neg = ~op[0] & rs_data[31];
      b_neg = ~op[0] & rt_data[31];
      a_mag = a_neg ? (~rs_data + 32'd1) : rs_data;
      b_mag = b_neg ? (~rt_data + 32'd1) : rt_data;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && !op[2]) state_nxt = CALC;
         CALC:    if (count == 5'd31) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy  = (state != IDLE);
   assign stall = rd_req & busy;

   // acc = {partial product, remaining multiplier} for multiply, {remainder, quotient} for divide.
   always_comb begin
      mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd_b} : 33'd0);
      mul_next = {mul_sum, acc[31:1]};
      div_diff = acc[63:31] - {1'b0, opnd_b};
      if (!div_diff[32])
         div_next = {div_diff[31:0], acc[30:0], 1'b1};
      else
         div_next = {acc[62:0], 1'b0};
   end

   always_comb begin
      prod_neg = ~acc + 64'd1;
      fix_hi   = acc[63:32];
      fix_lo   = acc[31:0];
      if (!is_div) begin
         if (neg_res) begin
            fix_hi = prod_neg[63:32];
            fix_lo = prod_neg[31:0];
         end
      end else if (div_zero) begin
         fix_hi = rs_save;
         fix_lo = 32'hFFFF_FFFF;
      end else begin
         if (neg_res) fix_lo = ~acc[31:0] + 32'd1;
         if (neg_rem) fix_hi = ~acc[63:32] + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= 5'd0;
         hi    <= 32'd0;
         lo    <= 32'd0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= (state == FIX);
         case (state)
            IDLE: begin
               if (start) begin
                  if (!op[2]) begin
                     count    <= 5'd0;
                     is_div   <= op[1];
                     neg_res  <= a_neg ^ b_neg;
                     neg_rem  <= a_neg;
                     div_zero <= (rt_data == 32'd0);
                     rs_save  <= rs_data;
                     if (op[1]) begin
                        acc    <= {32'd0, a_mag};
                        opnd_b <= b_mag;
                     end else begin
                        acc    <= {32'd0, b_mag};
                        opnd_b <= a_mag;
                     end
                  end else if (op == OP_MTHI) begin
                     hi <= rs_data;
                  end else if (op == OP_MTLO) begin
                     lo <= rs_data;
                  end
               end
            end
            CALC: begin
               acc   <= is_div ? div_next : mul_next;
               count <= count + 5'd1;
            end
            FIX: begin
               hi <= fix_hi;
               lo <= fix_lo;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mips_cpu_muldiv_ctrl.md
MIPS_CPU_MULDIV_CTRL -- requirements
Module: mips_cpu_muldiv_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named `clk` and `reset`.
REQ-002 `clk  in  1` SHALL be the rising-edge clock for all state.
REQ-003 `reset  in  1` SHALL be the synchronous, active-high reset.
REQ-004 `start  in  1` SHALL request an operation; it is sampled only when busy=0.
REQ-005 `op  in  3` SHALL encode the operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
REQ-006 `rs_data  in  32` SHALL carry the multiplicand or dividend, or the MTHI/MTLO source.
REQ-007 `rt_data  in  32` SHALL carry the multiplier or divisor.
REQ-008 `rd_req  in  1` SHALL indicate that the decode stage is issuing MFHI/MFLO.
REQ-009 `busy  out  1` SHALL be high while an iterative operation is in progress (state != IDLE).
REQ-010 `done  out  1` SHALL be a registered, one-cycle pulse on completion of a MULT/MULTU/DIV/DIVU.
REQ-011 `stall  out  1` SHALL be combinational and equal to rd_req & busy.
REQ-012 `hi  out  32` and `lo  out  32` SHALL be the architectural HI/LO registers, registered outputs.

Function
REQ-013 The FSM SHALL have the states IDLE, CALC and FIX.
REQ-014 In IDLE with start=1 and op in 000-011, the block SHALL capture operands and sign flags and load iteration count 0 at edge E0, then enter CALC.
REQ-015 The block SHALL run exactly 32 CALC cycles, one bit per cycle: shift-add for multiply, restoring shift-subtract for divide on operand magnitudes; it SHALL enter FIX after the 32nd.
REQ-016 At the FIX edge (E33), the block SHALL apply sign correction, write HI and LO, and return to IDLE; done SHALL be 1 for the following cycle only.
REQ-017 Latency SHALL be fixed at 33 cycles regardless of operand values: busy is high from after E0 until E33, and new HI/LO are visible after E33.
REQ-018 MULT/MULTU SHALL produce a 64-bit product with HI=[63:32] and LO=[31:0]; MULT is signed two's-complement and MULTU is unsigned.
REQ-019 DIV/DIVU SHALL set LO=quotient and HI=remainder; for DIV the quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-020 On divide-by-zero (either signedness), the block SHALL still take the full 33-cycle latency and produce LO=32'hFFFFFFFF, HI=rs_data.
REQ-021 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL produce LO=32'h80000000, HI=0.
REQ-022 MTHI/MTLO in IDLE SHALL write HI (resp. LO) from rs_data at the same edge, with no busy and no done.
REQ-023 start while busy=1 SHALL be ignored (no queueing), including MTHI/MTLO; operands captured at E0 SHALL be unaffected by later input changes.
REQ-024 The op encodings 11x SHALL leave all state unchanged.
REQ-025 HI/LO SHALL hold their previous values throughout CALC and FIX, and change only at the FIX edge, on an MTHI/MTLO write, or on reset.
REQ-026 If rd_req and start arrive in the same IDLE cycle, stall SHALL be 0 and hi/lo SHALL present the pre-operation values.

Reset
REQ-027 When reset=1 at a clock edge, the block SHALL set state=IDLE, count=0, hi=0, lo=0, busy=0 and done=0, in any state.
REQ-028 On reset mid-operation, the block SHALL abandon the operation with no HI/LO update and no done pulse.
REQ-029 The cycle after reset deasserts SHALL accept start normally.

Verification
REQ-030 The bench SHALL cover: MULT rs=32'hFFFFFFFF, rt=2 -> after 33 cycles hi=32'hFFFFFFFF, lo=32'hFFFFFFFE, done pulses once.
REQ-031 The bench SHALL cover: MULTU rs=32'hFFFFFFFF, rt=2 -> hi=1, lo=32'hFFFFFFFE; busy high for exactly 33 cycles.
REQ-032 The bench SHALL cover: DIV rs=-7 (32'hFFFFFFF9), rt=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU rs=7, rt=0 -> lo=32'hFFFFFFFF, hi=7.
REQ-033 The bench SHALL cover: MTLO 32'h12345678 in IDLE -> lo=32'h12345678 next cycle, busy=0, done=0; then MULT started, with MTHI 1 issued at cycle 5 -> MTHI ignored and hi equals the product high word.
REQ-034 The bench SHALL cover: rd_req=1 held during a DIV -> stall=1 exactly while busy=1, and stall=0 in the cycle done=1.
REQ-035 The bench SHALL cover: reset asserted at cycle 10 of a MULTU -> next cycle busy=0, hi=lo=0, no done; a new MULT started immediately after completes correctly.
